// File: rtl/clock_divider_sequencer_if.sv
// Divide-factor request channel between a requester (master) and clock_divider_sequencer (slave).
interface clock_divider_sequencer_if #(
   parameter int unsigned DIV_WIDTH = 32
);
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [DIV_WIDTH-1:0] cfg_div;
   logic                 cfg_err;

   modport master (output cfg_valid, output cfg_div, input cfg_ready, input cfg_err);
   modport slave  (input cfg_valid, input cfg_div, output cfg_ready, output cfg_err);
endinterface

// File: rtl/clock_divider_sequencer.sv
// Sequences reset and divide factor of an integer clock divider; asserts locked once it has settled.
// Optional macro DIV_SEQ_CLAMP_EN: clamp out-of-range requests instead of rejecting them.
module clock_divider_sequencer #(
   parameter int unsigned DIV_WIDTH      = 32,
   parameter int unsigned DEFAULT_DIV    = 2,
   parameter int unsigned MIN_DIV        = 2,
   parameter int unsigned MAX_DIV        = 65535,
   parameter int unsigned HOLD_CYCLES    = 4,
   parameter int unsigned SETTLE_PERIODS = 2
) (
   input  logic                     clock_i,
   input  logic                     reset,
   input  logic                     en,
   clock_divider_sequencer_if.slave cfg,
   output logic [DIV_WIDTH-1:0]     div_factor,
   output logic                     div_reset,
   output logic                     locked,
   output logic                     busy
);
   localparam int unsigned CNT_W = DIV_WIDTH + 8;
   localparam logic [CNT_W-1:0]     HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [DIV_WIDTH-1:0] DEF_DIV   = DIV_WIDTH'(DEFAULT_DIV);
   localparam logic [DIV_WIDTH-1:0] LO_DIV    = DIV_WIDTH'(MIN_DIV);
   localparam logic [DIV_WIDTH-1:0] HI_DIV    = DIV_WIDTH'(MAX_DIV);

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_SETTLE,
      ST_LOCKED,
      ST_DISABLED
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] div_factor_q, div_factor_d;
   logic                 div_reset_q, div_reset_d;
   logic                 locked_q, locked_d;
   logic                 busy_q, busy_d;
   logic                 cfg_ready_q, cfg_ready_d;
   logic                 cfg_err_q, cfg_err_d;

   logic                 accept;
   logic                 req_legal;
   logic [DIV_WIDTH-1:0] req_div;
   logic [CNT_W-1:0]     settle_target;

   // Request qualification: clamp into range or flag as illegal
   always_comb begin
      req_div   = cfg.cfg_div;
      req_legal = 1'b0;
`ifdef DIV_SEQ_CLAMP_EN
      req_legal = 1'b1;
      if (cfg.cfg_div < LO_DIV) begin
         req_div = LO_DIV;
      end else if (cfg.cfg_div > HI_DIV) begin
         req_div = HI_DIV;
      end
`else
      req_legal = (cfg.cfg_div >= LO_DIV) && (cfg.cfg_div <= HI_DIV);
`endif
   end

   // Next state, counters and registered-output values
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      div_factor_d  = div_factor_q;
      cfg_err_d     = 1'b0;
      accept        = cfg.cfg_valid && cfg_ready_q;
      settle_target = CNT_W'(SETTLE_PERIODS) * CNT_W'(div_factor_q);

      case (state_q)
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = ST_SETTLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_SETTLE: begin
            if ((cnt_q + CNT_W'(1)) == settle_target) begin
               state_d = ST_LOCKED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_LOCKED: begin
            cnt_d = '0;
         end
         ST_DISABLED: begin
            if (en) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_HOLD;
            cnt_d   = '0;
         end
      endcase

      // Factor only moves while the divider is (or is about to be) held in reset
      if (accept) begin
         if (req_legal) begin
            div_factor_d = req_div;
            if (state_q == ST_LOCKED) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         end else begin
            cfg_err_d = 1'b1;
         end
      end

      if (!en) begin
         state_d = ST_DISABLED;
         cnt_d   = '0;
      end

`ifdef DIV_SEQ_CLAMP_EN
      cfg_err_d = 1'b0;
`endif

      div_reset_d = (state_d == ST_HOLD) || (state_d == ST_DISABLED);
      locked_d    = (state_d == ST_LOCKED);
      busy_d      = (state_d == ST_HOLD) || (state_d == ST_SETTLE);
      cfg_ready_d = (state_d == ST_LOCKED) || (state_d == ST_DISABLED);
   end

   always_ff @(posedge clock_i) begin
      if (reset) begin
         state_q      <= ST_HOLD;
         cnt_q        <= '0;
         div_factor_q <= DEF_DIV;
         div_reset_q  <= 1'b1;
         locked_q     <= 1'b0;
         busy_q       <= 1'b1;
         cfg_ready_q  <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         div_factor_q <= div_factor_d;
         div_reset_q  <= div_reset_d;
         locked_q     <= locked_d;
         busy_q       <= busy_d;
         cfg_ready_q  <= cfg_ready_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   assign div_factor    = div_factor_q;
   assign div_reset     = div_reset_q;
   assign locked        = locked_q;
   assign busy          = busy_q;
   assign cfg.cfg_ready = cfg_ready_q;
   assign cfg.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_clock_divider_sequencer.sv
// Bench for clock_divider_sequencer: directed literal checks plus random traffic against a timeline model.
module tb_clock_divider_sequencer;
   localparam int unsigned DIV_WIDTH      = 32;
   localparam int unsigned DEFAULT_DIV    = 2;
   localparam int unsigned MIN_DIV        = 2;
   localparam int unsigned MAX_DIV        = 65535;
   localparam int unsigned HOLD_CYCLES    = 4;
   localparam int unsigned SETTLE_PERIODS = 2;

   logic                 clk;
   logic                 reset;
   logic                 en;
   logic [DIV_WIDTH-1:0] div_factor;
   logic                 div_reset;
   logic                 locked;
   logic                 busy;

   int checks = 0;
   int errors = 0;

   clock_divider_sequencer_if #(.DIV_WIDTH(DIV_WIDTH)) cfg_if ();

   clock_divider_sequencer #(
      .DIV_WIDTH(DIV_WIDTH), .DEFAULT_DIV(DEFAULT_DIV), .MIN_DIV(MIN_DIV),
      .MAX_DIV(MAX_DIV), .HOLD_CYCLES(HOLD_CYCLES), .SETTLE_PERIODS(SETTLE_PERIODS)
   ) dut (
      .clock_i(clk), .reset(reset), .en(en), .cfg(cfg_if),
      .div_factor(div_factor), .div_reset(div_reset), .locked(locked), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: outputs follow from elapsed cycles since the last sequence start
   longint      n = 0;
   longint      start = 0;
   bit          dis = 0;
   bit          mvalid = 0;
   logic [31:0] m_factor = 32'(DEFAULT_DIV);
   bit          m_err = 0;
   bit          e_rst = 1, e_lock = 0, e_busy = 1, e_rdy = 0;

   function automatic void req_eval(input logic [31:0] d, output bit ok, output logic [31:0] f);
`ifdef DIV_SEQ_CLAMP_EN
      ok = 1'b1;
      f  = (d < MIN_DIV) ? 32'(MIN_DIV) : (d > MAX_DIV) ? 32'(MAX_DIV) : d;
`else
      ok = (d >= MIN_DIV) && (d <= MAX_DIV);
      f  = d;
`endif
   endfunction

   always @(posedge clk) begin : model
      bit          ok, prev_rdy, prev_lock;
      logic [31:0] f;
      longint      el;
      n++;
      if (reset) begin
         mvalid   = 1'b1;
         dis      = 1'b0;
         start    = n;
         m_factor = 32'(DEFAULT_DIV);
         m_err    = 1'b0;
      end else if (mvalid) begin
         prev_rdy  = e_rdy;
         prev_lock = e_lock;
         m_err     = 1'b0;
         if (cfg_if.cfg_valid && prev_rdy) begin
            req_eval(cfg_if.cfg_div, ok, f);
            if (ok) begin
               if (prev_lock) start = n;
               m_factor = f;
            end else begin
               m_err = 1'b1;
            end
         end
         if (!en) dis = 1'b1;
         else if (dis) begin
            dis   = 1'b0;
            start = n;
         end
      end
      if (dis) begin
         e_rst = 1; e_lock = 0; e_busy = 0; e_rdy = 1;
      end else begin
         el     = n - start;
         e_rst  = (el < HOLD_CYCLES);
         e_lock = (el >= longint'(HOLD_CYCLES) + longint'(SETTLE_PERIODS) * longint'(m_factor));
         e_busy = !e_lock;
         e_rdy  = e_lock;
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         check("div_reset", 32'(div_reset), 32'(e_rst));
         check("locked", 32'(locked), 32'(e_lock));
         check("busy", 32'(busy), 32'(e_busy));
         check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(e_rdy));
         check("cfg_err", 32'(cfg_if.cfg_err), 32'(m_err));
         check("div_factor", div_factor, m_factor);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic v, input logic [31:0] d);
      @(negedge clk);
      cfg_if.cfg_valid = v;
      cfg_if.cfg_div   = d;
   endtask

   task automatic wait_locked(output int cyc, output int rst_hi);
      cyc    = 0;
      rst_hi = 0;
      while (!locked && cyc < 1000) begin
         if (div_reset) rst_hi++;
         tick();
         cyc++;
      end
      if (!locked) begin
         checks++;
         errors++;
         $display("FAIL lock_timeout actual=unlocked required=locked at %0t", $time);
      end
   endtask

   task automatic check_reset_values();
      check("rst_div_reset", 32'(div_reset), 32'd1);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
      check("rst_err", 32'(cfg_if.cfg_err), 32'd0);
      check("rst_factor", div_factor, 32'd2);
   endtask

   initial begin
      int cyc, hi;
      logic [31:0] d;
      reset = 1'b1;
      en = 1'b1;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_div = '0;
      repeat (3) tick();
      check_reset_values();

      @(negedge clk) reset = 1'b0;
      wait_locked(cyc, hi);
      check("boot_lock_cycles", 32'(cyc), 32'd8);
      check("boot_hold_cycles", 32'(hi), 32'd4);

      drive_req(1'b1, 32'd3);
      tick();
      check("req3_locked", 32'(locked), 32'd0);
      check("req3_div_reset", 32'(div_reset), 32'd1);
      check("req3_factor", div_factor, 32'd3);
      check("req3_ready", 32'(cfg_if.cfg_ready), 32'd0);
      drive_req(1'b0, 32'd0);
      wait_locked(cyc, hi);
      check("req3_lock_cycles", 32'(cyc), 32'd10);
      check("req3_hold_cycles", 32'(hi), 32'd4);

`ifndef DIV_SEQ_CLAMP_EN
      drive_req(1'b1, 32'd1);
      tick();
      check("ill1_err", 32'(cfg_if.cfg_err), 32'd1);
      check("ill1_factor", div_factor, 32'd3);
      check("ill1_locked", 32'(locked), 32'd1);
      drive_req(1'b1, 32'd70000);
      tick();
      check("ill70000_err", 32'(cfg_if.cfg_err), 32'd1);
      check("ill70000_factor", div_factor, 32'd3);
      check("ill70000_ready", 32'(cfg_if.cfg_ready), 32'd1);
      drive_req(1'b0, 32'd0);
      tick();
      check("err_single_cycle", 32'(cfg_if.cfg_err), 32'd0);

      drive_req(1'b1, 32'd4);
      tick();
      drive_req(1'b0, 32'd0);
      repeat (5) tick();
      check("settle_div_reset", 32'(div_reset), 32'd0);
      @(negedge clk) en = 1'b0;
      tick();
      check("dis_div_reset", 32'(div_reset), 32'd1);
      check("dis_locked", 32'(locked), 32'd0);
      check("dis_busy", 32'(busy), 32'd0);
      drive_req(1'b1, 32'd65535);
      tick();
      check("dis_max_factor", div_factor, 32'd65535);
      drive_req(1'b1, 32'd65536);
      tick();
      check("dis_over_err", 32'(cfg_if.cfg_err), 32'd1);
      check("dis_over_factor", div_factor, 32'd65535);
      drive_req(1'b1, 32'd5);
      tick();
      check("dis_req5_factor", div_factor, 32'd5);
      @(negedge clk);
      cfg_if.cfg_valid = 1'b0;
      en = 1'b1;
      tick();
      wait_locked(cyc, hi);
      check("req5_lock_cycles", 32'(cyc), 32'd14);
`else
      drive_req(1'b1, 32'd1);
      tick();
      check("clamp_lo_err", 32'(cfg_if.cfg_err), 32'd0);
      check("clamp_lo_factor", div_factor, 32'd2);
      drive_req(1'b0, 32'd0);
      wait_locked(cyc, hi);
      check("clamp_lo_lock_cycles", 32'(cyc), 32'd8);
      @(negedge clk) en = 1'b0;
      drive_req(1'b1, 32'd70000);
      tick();
      check("clamp_hi_factor", div_factor, 32'd65535);
      drive_req(1'b1, 32'd5);
      @(negedge clk);
      cfg_if.cfg_valid = 1'b0;
      en = 1'b1;
      tick();
      wait_locked(cyc, hi);
`endif

      drive_req(1'b1, 32'd7);
      tick();
      check("req7_factor", div_factor, 32'd7);
      @(negedge clk);
      cfg_if.cfg_valid = 1'b0;
      reset = 1'b1;
      tick();
      check_reset_values();
      @(negedge clk) reset = 1'b0;

      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 39) == 0) en = !en;
         if (!(cfg_if.cfg_valid && !cfg_if.cfg_ready)) begin
            cfg_if.cfg_valid = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) < 7) begin
               d = 32'($urandom_range(MIN_DIV, 10));
            end else begin
`ifdef DIV_SEQ_CLAMP_EN
               d = 32'($urandom_range(0, 1));
`else
               case ($urandom_range(0, 3))
                  0: d = 32'd0;
                  1: d = 32'd1;
                  2: d = 32'(MAX_DIV + 1);
                  default: d = 32'hFFFF_FFFF;
               endcase
`endif
            end
            cfg_if.cfg_div = d;
         end
      end
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
